neuron_mac_engine: RTL
======================

// Module: neuron_mac_engine
// PURPOSE
//  Multi-cycle signed MAC neuron: N input/weight pairs, LANES products per cycle, scaled bias, layer shift, ReLU.
//  Replaces the single-product combinational neuron datapath with an FSM-sequenced engine and start/done handshake.
//  Sits between the layer controller (issues start) and the next layer's input buffer (takes result on done).
// PARAMETERS
//  N         10                          inputs per neuron (>=1)
//  DW        8                           signed data width of inp, w, bias, result
//  LANES     1                           products per MAC cycle (1..N)
//  ACC_W     2*DW+$clog2(N)+1            accumulator width (21 at defaults)
//  HID_SHIFT 9                           arithmetic right shift applied when hidden=1
//  OUT_SHIFT 7                           arithmetic right shift applied when hidden=0
// PORTS
//  clk     in   1        clock, rising edge
//  rst     in   1        asynchronous, active-low reset
//  start   in   1        request; sampled only in IDLE
//  clr     in   1        synchronous abort; returns to IDLE, no done
//  inp     in   DW*N     input vector; element i = inp[DW*i +: DW], signed
//  w       in   DW*N     weight vector; same packing, signed
//  bias    in   DW       signed bias
//  hidden  in   1        1 = hidden layer (HID_SHIFT), 0 = output layer (OUT_SHIFT)
//  busy    out  1        high in every state except IDLE
//  done    out  1        one-cycle pulse; result valid from this cycle
//  result  out  DW       activated output; holds until next done
// BEHAVIOUR
//  - Reset (rst=0, async): state=IDLE, acc=0, idx=0, busy=0, done=0, result=0; all latched operands cleared.
//  - States: IDLE -> MAC -> BIAS -> ACT -> IDLE.
//  - IDLE: start=1 latches inp, w, bias, hidden into internal regs; acc<=0, idx<=0; go MAC. Inputs may change afterwards.
//  - MAC: acc += sum of lanes j=0..LANES-1 of inp[idx+j]*w[idx+j] (signed DWxDW -> 2*DW, sign-extended to ACC_W);
//    lanes with idx+j>=N contribute 0; idx += LANES; after K=ceil(N/LANES) MAC cycles go BIAS.
//  - BIAS: acc += sign_ext(bias) * (2^(DW-1)-1) (bias scaled to product Q-format); go ACT.
//  - ACT: s = acc >>> (hidden ? HID_SHIFT : OUT_SHIFT); ReLU: s<0 -> 0; result <= clip/trunc(s) (see CONFIGURATION);
//    done <= 1 for exactly one cycle; go IDLE.
//  - Latency: start sampled at edge 0; done high after edge K+2 (N=10, LANES=1: edge 12; LANES=2: edge 7).
//  - start while busy: ignored, not queued. start in the cycle done is high: accepted (FSM already IDLE).
//  - clr=1: any state -> IDLE next edge, acc/idx cleared, done stays 0, result keeps previous value. clr beats start.
//  - Accumulator wraps modulo 2^ACC_W; no overflow flag (default ACC_W cannot overflow for any operands).
//  - Async reset mid-operation: immediate return to reset values; no done for the aborted request.
// CONFIGURATION
//  NEURON_SAT_EN defined: positive s > 2^(DW-1)-1 clips to 2^(DW-1)-1 (127 at DW=8).
//  NEURON_SAT_EN undefined: result = s[DW-1:0] (plain truncation after ReLU; may appear negative on overflow).
// TESTING
//  1) N=10,LANES=1, all inp=64, w=64, bias=0, hidden=0 -> acc=40960, s=320; SAT_EN: result=127, else 64; done after edge 12.
//  2) Same operands, hidden=1 -> s=40960>>>9=80 -> result=80 both builds.
//  3) all inp=64, w=-64, bias=0 -> acc=-40960, ReLU -> result=0, done still pulses once.
//  4) inp=0, bias=10, hidden=0 -> acc=1270, s=9 -> result=9; bias=-10 -> result=0.
//  5) LANES=2, test 1 operands -> same result, done after edge 7; start re-asserted while busy -> ignored, single done.
//  6) clr at MAC cycle 4 -> IDLE next edge, no done, result unchanged; rst low mid-MAC -> busy/done/result=0 immediately.

Source files
------------

// File: rtl/neuron_mac_engine.sv
// ============================================================================
// Module   : neuron_mac_engine
// Purpose  : Multi-cycle signed MAC neuron (N pairs, LANES products per cycle,
//            scaled bias, layer shift, ReLU) with a start/done handshake.
//            Optional macro NEURON_SAT_EN: clip positive overflow to 2^(DW-1)-1.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module neuron_mac_engine #(
  parameter int N         = 10,
  parameter int DW        = 8,
  parameter int LANES     = 1,
  parameter int ACC_W     = 2*DW + $clog2(N) + 1,
  parameter int HID_SHIFT = 9,
  parameter int OUT_SHIFT = 7
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            clr,
  input  logic [DW*N-1:0] inp,
  input  logic [DW*N-1:0] w,
  input  logic [DW-1:0]   bias,
  input  logic            hidden,
  output logic            busy,
  output logic            done,
  output logic [DW-1:0]   result
);

  localparam int IDX_W = $clog2(N + LANES + 1);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_mac  = 2'd1;
  localparam logic [1:0] c_st_bias = 2'd2;
  localparam logic [1:0] c_st_act  = 2'd3;

  localparam logic [IDX_W-1:0]        c_n        = IDX_W'(N);
  localparam logic [IDX_W-1:0]        c_lanes    = IDX_W'(LANES);
  localparam logic signed [ACC_W-1:0] c_q_one    = ACC_W'((1 << (DW-1)) - 1);
  localparam logic signed [ACC_W-1:0] c_acc_zero = '0;

  logic [1:0]               r_state;
  logic [DW*N-1:0]          r_inp;
  logic [DW*N-1:0]          r_w;
  logic signed [DW-1:0]     r_bias;
  logic                     r_hidden;
  logic signed [ACC_W-1:0]  r_acc;
  logic [IDX_W-1:0]         r_idx;
  logic                     r_done;
  logic [DW-1:0]            r_result;

  logic signed [2*DW-1:0]   w_prod [LANES];
  logic signed [ACC_W-1:0]  w_mac_sum;
  logic signed [ACC_W-1:0]  w_bias_term;
  logic signed [ACC_W-1:0]  w_shifted;
  logic [DW-1:0]            w_act;

  // Operands are shifted down each MAC cycle, so lane j always reads a fixed
  // slice; zeros shifted in make lanes past the last element contribute 0.
  for (genvar j = 0; j < LANES; j++) begin : g_lane
    logic signed [DW-1:0] w_a;
    logic signed [DW-1:0] w_b;
    assign w_a       = r_inp[DW*j +: DW];
    assign w_b       = r_w[DW*j +: DW];
    assign w_prod[j] = (2*DW)'(w_a) * (2*DW)'(w_b);
  end

  always_comb begin
    w_mac_sum = '0;
    for (int j = 0; j < LANES; j++) begin
      w_mac_sum = w_mac_sum + ACC_W'(w_prod[j]);
    end
  end

  assign w_bias_term = ACC_W'(r_bias) * c_q_one;
  assign w_shifted   = r_hidden ? (r_acc >>> HID_SHIFT) : (r_acc >>> OUT_SHIFT);

  always_comb begin
    w_act = '0;
    if (w_shifted > c_acc_zero) begin
`ifdef NEURON_SAT_EN
      if (w_shifted > c_q_one) begin
        w_act = c_q_one[DW-1:0];
      end else begin
        w_act = w_shifted[DW-1:0];
      end
`else
      w_act = w_shifted[DW-1:0];
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= c_st_idle;
      r_inp    <= '0;
      r_w      <= '0;
      r_bias   <= '0;
      r_hidden <= 1'b0;
      r_acc    <= '0;
      r_idx    <= '0;
      r_done   <= 1'b0;
      r_result <= '0;
    end else begin
      r_done <= 1'b0;
      if (clr) begin
        r_state <= c_st_idle;
        r_acc   <= '0;
        r_idx   <= '0;
      end else begin
        case (r_state)
          c_st_idle: begin
            if (start) begin
              r_inp    <= inp;
              r_w      <= w;
              r_bias   <= bias;
              r_hidden <= hidden;
              r_acc    <= '0;
              r_idx    <= '0;
              r_state  <= c_st_mac;
            end
          end
          c_st_mac: begin
            r_acc <= r_acc + w_mac_sum;
            r_inp <= r_inp >> (DW*LANES);
            r_w   <= r_w >> (DW*LANES);
            r_idx <= r_idx + c_lanes;
            if (r_idx + c_lanes >= c_n) begin
              r_state <= c_st_bias;
            end
          end
          c_st_bias: begin
            r_acc   <= r_acc + w_bias_term;
            r_state <= c_st_act;
          end
          c_st_act: begin
            r_result <= w_act;
            r_done   <= 1'b1;
            r_state  <= c_st_idle;
          end
          default: r_state <= c_st_idle;
        endcase
      end
    end
  end

  assign busy   = (r_state != c_st_idle);
  assign done   = r_done;
  assign result = r_result;

endmodule

`default_nettype wire
